sakebi_axis_frame_arb: RTL

SAKEBI_AXIS_FRAME_ARB -- requirements
Module: sakebi_axis_frame_arb

---
 rtl/sakebi_pkg.sv | 14 +
 rtl/sakebi_ifg_counter.sv | 35 +++
 rtl/sakebi_axis_frame_arb.sv | 114 +++++++++++
 3 files changed

// File: rtl/sakebi_pkg.sv
// Shared types and defaults for the sakebi two-source AXI-Stream frame arbiter.
package sakebi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_e;

    localparam int unsigned IFG_CYCLES_DEFAULT = 12;
    localparam int unsigned IFG_CNT_W          = 8;

endpackage

// File: rtl/sakebi_ifg_counter.sv
// Inter-frame gap down-counter: load, saturating decrement, zero flag.
module sakebi_ifg_counter
    import sakebi_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [IFG_CNT_W-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 zero_o
);

    logic [IFG_CNT_W-1:0] cnt_q;
    logic [IFG_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sakebi_axis_frame_arb.sv
// Two-source AXI-Stream arbiter: frame-atomic grants, alternating on ties,
// with a programmable idle gap after every completed frame.
module sakebi_axis_frame_arb
    import sakebi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IFG_CYCLES = IFG_CYCLES_DEFAULT
) (
    input  logic                  i_axis_ACLK,
    input  logic                  i_axis_ARESETn,
    input  logic                  i_s0_axis_TVALID,
    output logic                  o_s0_axis_TREADY,
    input  logic [DATA_WIDTH-1:0] i_s0_axis_TDATA,
    input  logic                  i_s0_axis_TLAST,
    input  logic                  i_s1_axis_TVALID,
    output logic                  o_s1_axis_TREADY,
    input  logic [DATA_WIDTH-1:0] i_s1_axis_TDATA,
    input  logic                  i_s1_axis_TLAST,
    output logic                  o_m_axis_TVALID,
    input  logic                  i_m_axis_TREADY,
    output logic [DATA_WIDTH-1:0] o_m_axis_TDATA,
    output logic                  o_m_axis_TLAST,
    output logic [1:0]            o_grant,
    output logic [15:0]           o_frame_cnt
);

    localparam logic [IFG_CNT_W-1:0] IFG_LOAD = IFG_CNT_W'(IFG_CYCLES - 1);

    arb_state_e  state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        gap_load, gap_dec, gap_zero;

    sakebi_ifg_counter u_ifg (
        .clk_i      (i_axis_ACLK),
        .rst_ni     (i_axis_ARESETn),
        .load_i     (gap_load),
        .load_val_i (IFG_LOAD),
        .dec_i      (gap_dec),
        .zero_o     (gap_zero)
    );

    always_comb begin
        state_d          = state_q;
        last_d           = last_q;
        frame_cnt_d      = frame_cnt_q;
        gap_load         = 1'b0;
        gap_dec          = 1'b0;
        o_s0_axis_TREADY = 1'b0;
        o_s1_axis_TREADY = 1'b0;
        o_m_axis_TVALID  = 1'b0;
        o_m_axis_TDATA   = '0;
        o_m_axis_TLAST   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // last_q is 1 when s1 was served last, so s0 wins the tie
                if (i_s0_axis_TVALID && i_s1_axis_TVALID) begin
                    state_d = last_q ? ST_GRANT0 : ST_GRANT1;
                end else if (i_s0_axis_TVALID) begin
                    state_d = ST_GRANT0;
                end else if (i_s1_axis_TVALID) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                o_m_axis_TVALID  = i_s0_axis_TVALID;
                o_m_axis_TDATA   = i_s0_axis_TVALID ? i_s0_axis_TDATA : '0;
                o_m_axis_TLAST   = i_s0_axis_TVALID & i_s0_axis_TLAST;
                o_s0_axis_TREADY = i_m_axis_TREADY;
                if (i_s0_axis_TVALID && i_m_axis_TREADY && i_s0_axis_TLAST) begin
                    state_d     = ST_GAP;
                    gap_load    = 1'b1;
                    last_d      = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            ST_GRANT1: begin
                o_m_axis_TVALID  = i_s1_axis_TVALID;
                o_m_axis_TDATA   = i_s1_axis_TVALID ? i_s1_axis_TDATA : '0;
                o_m_axis_TLAST   = i_s1_axis_TVALID & i_s1_axis_TLAST;
                o_s1_axis_TREADY = i_m_axis_TREADY;
                if (i_s1_axis_TVALID && i_m_axis_TREADY && i_s1_axis_TLAST) begin
                    state_d     = ST_GAP;
                    gap_load    = 1'b1;
                    last_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                gap_dec = 1'b1;
                if (gap_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
        if (!i_axis_ARESETn) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_grant     = {state_q == ST_GRANT1, state_q == ST_GRANT0};
    assign o_frame_cnt = frame_cnt_q;

endmodule
